// File: rtl/core_seq_pkg.sv
// Shared types and constants for the methane RV32I multicycle control sequencer.
package core_seq_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ERR_W   = 3;
  localparam int unsigned TIMER_W = 16;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int unsigned ERR_ILLEGAL  = 0;
  localparam int unsigned ERR_MISALIGN = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JAL     = 3'd4,
    CLS_JALR    = 3'd5,
    CLS_UPPER   = 3'd6,
    CLS_ILLEGAL = 3'd7
  } inst_cls_t;

  // Instruction redirects pc to its target instead of pc+4.
  function automatic logic uses_target(input inst_cls_t c, input logic taken);
    return (c == CLS_JAL) || (c == CLS_JALR) || ((c == CLS_BRANCH) && taken);
  endfunction

  function automatic logic writes_rd(input inst_cls_t c);
    return !((c == CLS_STORE) || (c == CLS_BRANCH));
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory request/ack handshake bundle for core_sequencer.
interface core_sequencer_if;
  import core_seq_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/seq_wait_timer.sv
// Consecutive-wait-cycle counter shared by the FETCH and MEM handshakes; limit 0 never expires.
module seq_wait_timer
  import core_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               en,
  input  logic [TIMER_W-1:0] limit,
  output logic               expire
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TIMER_W'(1);
    end
  end

  // Fires on the limit-th consecutive un-acked cycle, so the requester drops out next cycle.
  assign expire = en && (limit != '0) && (cnt == (limit - TIMER_W'(1)));

endmodule

// File: rtl/core_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer owning the pc; sticky HALT on fault.
// Optional CORE_SEQ_PERF_EN adds cycle_cnt / instret_cnt performance counters.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned     MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  core_sequencer_if.master  mem,
  output logic              ir_we,
  output logic              dec_en,
  input  logic [2:0]        cls,
  output logic              exec_en,
  input  logic              br_taken,
  input  logic [XLEN-1:0]   target,
  output logic              rd_we,
  output logic [XLEN-1:0]   pc,
  output logic              busy,
  output logic              halted,
  output logic [ERR_W-1:0]  err
`ifdef CORE_SEQ_PERF_EN
  ,
  output logic [63:0]       cycle_cnt,
  output logic [63:0]       instret_cnt
`endif
);

  seq_state_t      state;
  seq_state_t      state_nx;
  inst_cls_t       cls_in;
  inst_cls_t       cls_q;
  logic            taken_q;
  logic [XLEN-1:0] target_q;
  logic            stop_pend;
  logic            stop_req;
  logic            imem_req_c;
  logic            dmem_req_c;
  logic            dmem_we_c;
  logic            pc_ld;
  logic [ERR_W-1:0] err_set;
  logic            wait_en;
  logic            expire;

  assign cls_in   = inst_cls_t'(cls);
  assign stop_req = stop_pend || stop;
  assign busy     = (state != S_IDLE) && (state != S_HALT);
  assign halted   = (state == S_HALT);

  assign mem.imem_req  = imem_req_c;
  assign mem.imem_addr = pc;
  assign mem.dmem_req  = dmem_req_c;
  assign mem.dmem_we   = dmem_we_c;

  // Kept outside the FSM block so the timer's expire does not loop back through it.
  assign wait_en = ((state == S_FETCH) && !mem.imem_ack) ||
                   ((state == S_MEM)   && !mem.dmem_ack);

  seq_wait_timer u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wait_en),
    .en     (wait_en),
    .limit  (TIMER_W'(MEM_TIMEOUT)),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ir_we      = 1'b0;
    dec_en     = 1'b0;
    exec_en    = 1'b0;
    rd_we      = 1'b0;
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    pc_ld      = 1'b0;
    err_set    = '0;

    case (state)
      S_IDLE: begin
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem.imem_ack) begin
          ir_we    = 1'b1;
          state_nx = S_DECODE;
        end else if (expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_nx             = S_HALT;
        end
      end
      S_DECODE: begin
        dec_en   = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        if (cls_in == CLS_ILLEGAL) begin
          err_set[ERR_ILLEGAL] = 1'b1;
          state_nx             = S_HALT;
        end else if (uses_target(cls_in, br_taken) && (target[1:0] != 2'b00)) begin
          err_set[ERR_MISALIGN] = 1'b1;
          state_nx              = S_HALT;
        end else if ((cls_in == CLS_LOAD) || (cls_in == CLS_STORE)) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls_q == CLS_STORE);
        if (mem.dmem_ack) begin
          state_nx = S_WB;
        end else if (expire) begin
          err_set[ERR_TIMEOUT] = 1'b1;
          state_nx             = S_HALT;
        end
      end
      S_WB: begin
        rd_we    = writes_rd(cls_q);
        pc_ld    = 1'b1;
        state_nx = stop_req ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // A reset cycle abandons the instruction: no strobe may escape alongside it.
    if (rst) begin
      ir_we      = 1'b0;
      dec_en     = 1'b0;
      exec_en    = 1'b0;
      rd_we      = 1'b0;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      err       <= '0;
      cls_q     <= CLS_ALU;
      taken_q   <= 1'b0;
      target_q  <= '0;
      stop_pend <= 1'b0;
    end else begin
      err <= err | err_set;
      if (exec_en) begin
        cls_q    <= cls_in;
        taken_q  <= br_taken;
        target_q <= target;
      end
      if (pc_ld) begin
        pc <= uses_target(cls_q, taken_q) ? target_q : pc + XLEN'(4);
      end
      // A start+stop in IDLE still runs one instruction before stopping.
      if (state_nx == S_IDLE) begin
        stop_pend <= 1'b0;
      end else if (stop && (busy || ((state == S_IDLE) && start))) begin
        stop_pend <= 1'b1;
      end
    end
  end

`ifdef CORE_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (busy)          cycle_cnt   <= cycle_cnt + 64'd1;
      if (state == S_WB) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer with a fetch-address scoreboard.
module tb_core_sequencer;
  import core_seq_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned TMO    = 4;

  logic        clk = 1'b0;
  logic        rst, start, stop, br_taken;
  logic [2:0]  cls;
  logic [31:0] target;
  logic        ir_we, dec_en, exec_en, rd_we, busy, halted;
  logic [31:0] pc;
  logic [2:0]  err;
`ifdef CORE_SEQ_PERF_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  core_sequencer_if mem();

  core_sequencer #(.RESET_PC(RST_PC), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mem(mem),
    .ir_we(ir_we), .dec_en(dec_en), .cls(cls), .exec_en(exec_en),
    .br_taken(br_taken), .target(target), .rd_we(rd_we), .pc(pc),
    .busy(busy), .halted(halted), .err(err)
`ifdef CORE_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] pc_m;
  logic [2:0]  err_m;
  longint      instret_m;
  logic [31:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pc_m = RST_PC; err_m = '0; instret_m = 0;
    exp_q.delete();
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_imem_req", mem.imem_req, 0);
    check("rst_dmem_req", mem.dmem_req, 0);
  endtask

  task automatic start_run(input logic with_stop);
    exp_q.push_back(pc_m);
    start = 1'b1; stop = with_stop;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      mem.imem_ack = 1'b0;
      #1;
      check("imem_req_wait", mem.imem_req, 1);
      check("ir_we_wait", ir_we, 0);
      tick();
    end
    mem.imem_ack = 1'b1;
    #1;
    check("imem_req_ack", mem.imem_req, 1);
    check("ir_we", ir_we, 1);
    check("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) check("imem_addr", mem.imem_addr, exp_q.pop_front());
    tick();
    mem.imem_ack = 1'b0;
  endtask

  // Drives one instruction from FETCH; expected next fetch address is pushed at WB.
  task automatic do_instr(input logic [2:0] c, input logic tk, input logic [31:0] tg,
                          input int iw, input int dw, input logic stp, input logic to_idle);
    logic        use_tgt;
    logic [31:0] npc;
    use_tgt = (c == CLS_JAL) || (c == CLS_JALR) || ((c == CLS_BRANCH) && tk);
    fetch(iw);
    #1;
    check("dec_en", dec_en, 1);
    check("busy_dec", busy, 1);
    tick();
    cls = c; br_taken = tk; target = tg; stop = stp;
    #1;
    check("exec_en", exec_en, 1);
    check("dec_en_once", dec_en, 0);
    tick();
    cls = CLS_ILLEGAL; br_taken = ~tk; target = 32'hDEAD_BEEF; stop = 1'b0;
    if ((c == CLS_ILLEGAL) || (use_tgt && (tg[1:0] != 2'b00))) begin
      if (c == CLS_ILLEGAL) err_m[ERR_ILLEGAL] = 1'b1;
      else                  err_m[ERR_MISALIGN] = 1'b1;
      #1;
      check("halted", halted, 1);
      check("err_halt", err, err_m);
      check("pc_hold", pc, pc_m);
      check("busy_halt", busy, 0);
      check("imem_req_halt", mem.imem_req, 0);
      return;
    end
    if ((c == CLS_LOAD) || (c == CLS_STORE)) begin
      for (int i = 0; i < dw; i++) begin
        mem.dmem_ack = 1'b0;
        #1;
        check("dmem_req_wait", mem.dmem_req, 1);
        check("dmem_we_wait", mem.dmem_we, c == CLS_STORE);
        check("rd_we_mem", rd_we, 0);
        tick();
      end
      mem.dmem_ack = 1'b1;
      #1;
      check("dmem_req_ack", mem.dmem_req, 1);
      check("dmem_we_ack", mem.dmem_we, c == CLS_STORE);
      tick();
      mem.dmem_ack = 1'b0;
    end
    npc = use_tgt ? tg : pc_m + 32'd4;
    #1;
    check("rd_we", rd_we, !((c == CLS_STORE) || (c == CLS_BRANCH)));
    check("dmem_req_wb", mem.dmem_req, 0);
    if (!to_idle) exp_q.push_back(npc);
    tick();
    pc_m = npc;
    instret_m++;
    #1;
    check("pc", pc, pc_m);
    check("rd_we_once", rd_we, 0);
    if (to_idle) begin
      check("busy_idle", busy, 0);
      check("imem_req_idle", mem.imem_req, 0);
    end
`ifdef CORE_SEQ_PERF_EN
    check("instret", instret_cnt, 64'(instret_m));
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; cls = '0; br_taken = 1'b0; target = '0;
    mem.imem_ack = 1'b0; mem.dmem_ack = 1'b0;
    do_reset();

    // ALU run, memory ops with waits, branches, jumps, pc wrap
    start_run(1'b0);
    do_instr(CLS_ALU,    1'b0, 32'h0,         0, 0, 1'b0, 1'b0);
    do_instr(CLS_ALU,    1'b0, 32'h0,         0, 0, 1'b0, 1'b0);
    do_instr(CLS_ALU,    1'b0, 32'h0,         0, 0, 1'b0, 1'b0);
    do_instr(CLS_LOAD,   1'b0, 32'h0,         0, 3, 1'b0, 1'b0);
    do_instr(CLS_BRANCH, 1'b1, 32'h40,        0, 0, 1'b0, 1'b0);
    do_instr(CLS_STORE,  1'b0, 32'h0,         1, 1, 1'b0, 1'b0);
    do_instr(CLS_BRANCH, 1'b0, 32'h83,        0, 0, 1'b0, 1'b0);
    do_instr(CLS_JAL,    1'b0, 32'hFFFF_FFFC, 2, 0, 1'b0, 1'b0);
    do_instr(CLS_ALU,    1'b0, 32'h0,         0, 0, 1'b0, 1'b0);
    do_instr(CLS_JALR,   1'b0, 32'h10,        0, 0, 1'b0, 1'b0);
    do_instr(CLS_UPPER,  1'b0, 32'h0,         0, 0, 1'b1, 1'b1);
    tick(); #1; check("idle_no_req", mem.imem_req, 0);
    tick(); #1; check("idle_pc", pc, pc_m);

    // start and stop together: exactly one instruction
    start_run(1'b1);
    do_instr(CLS_ALU, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1);
    tick(); #1; check("idle_after_one", busy, 0);

    // misaligned jump target, then start must be ignored in HALT
    start_run(1'b0);
    do_instr(CLS_JAL, 1'b0, 32'h42, 0, 0, 1'b0, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    #1;
    check("halt_start_ignored", halted, 1);
    check("halt_no_req", mem.imem_req, 0);
    do_reset();

    // illegal instruction
    start_run(1'b0);
    do_instr(CLS_ILLEGAL, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0);
    do_reset();

    // fetch timeout: no ack for MEM_TIMEOUT cycles
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      #1; check("tmo_req", mem.imem_req, 1);
      tick();
    end
    #1;
    check("tmo_halted", halted, 1);
    check("tmo_err", err, 3'b100);
    check("tmo_req_dropped", mem.imem_req, 0);
    do_reset();

    // ack exactly on the limit cycle wins over the timeout
    start_run(1'b0);
    do_instr(CLS_ALU, 1'b0, 32'h0, int'(TMO) - 1, 0, 1'b0, 1'b0);
    check("tmo_edge_err", err, 3'b000);
    check("tmo_edge_busy", busy, 1);
    do_reset();

    // reset during WB: no write, no pc update
    start_run(1'b0);
    fetch(0);
    tick();
    cls = CLS_ALU; br_taken = 1'b0; target = '0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_wb_rd_we", rd_we, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_wb_pc", pc, RST_PC);
    check("rst_wb_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
